// File: rtl/cache_pkg.sv
// Shared geometry, line payload type and address-split helpers for the
// 2-way lookup responder.
package cache_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned OFFSET_W = 5;
    localparam int unsigned INDEX_W  = 6;
    localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned SETS     = 32'd1 << INDEX_W;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } line_t;

    function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

endpackage

// File: rtl/cache_way_array.sv
// One way of the tag store: async read, sync write, single-edge clear of all
// valid bits.
module cache_way_array #(
    parameter int unsigned TAG_W   = cache_pkg::TAG_W,
    parameter int unsigned INDEX_W = cache_pkg::INDEX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag
);

    localparam int unsigned SETS = 32'd1 << INDEX_W;

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q [SETS];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (clear) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tags need no reset: a line is only ever read through its valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index] <= wr_tag;
        end
    end

endmodule

// File: rtl/cache_lookup_responder.sv
// 2-way set-associative tag store with LRU that answers the trace player's
// search cycles and keeps saturating reference/miss counters.
module cache_lookup_responder #(
    parameter int unsigned ADDR_W   = cache_pkg::ADDR_W,
    parameter int unsigned OFFSET_W = cache_pkg::OFFSET_W,
    parameter int unsigned INDEX_W  = cache_pkg::INDEX_W,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              state,
    input  logic              flush,
    output logic              hit,
    output logic [CNT_W-1:0]  ref_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned SETS  = 32'd1 << INDEX_W;

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               unused_offset;

    assign index         = addr_in[OFFSET_W +: INDEX_W];
    assign tag           = addr_in[ADDR_W-1 -: TAG_W];
    assign unused_offset = ^addr_in[OFFSET_W-1:0];

    logic               valid0, valid1;
    logic [TAG_W-1:0]   tag0, tag1;
    logic               match0, match1, any_match;
    logic               lookup;
    logic               victim;
    logic               alloc;
    logic [SETS-1:0]    lru_q;
    logic [CNT_W-1:0]   ref_q, miss_q;

    assign match0    = valid0 && (tag0 == tag);
    assign match1    = valid1 && (tag1 == tag);
    assign any_match = match0 || match1;
    assign lookup    = state && rst_n;
    assign hit       = lookup && any_match;

    // First invalid way wins; with both valid, the LRU bit names the victim.
    always_comb begin
        victim = 1'b0;
        if (!valid0) begin
            victim = 1'b0;
        end else if (!valid1) begin
            victim = 1'b1;
        end else begin
            victim = lru_q[index];
        end
    end

    assign alloc = lookup && !flush && !any_match;

    cache_way_array #(.TAG_W(TAG_W), .INDEX_W(INDEX_W)) u_way0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (flush),
        .rd_index (index),
        .rd_valid (valid0),
        .rd_tag   (tag0),
        .wr_en    (alloc && !victim),
        .wr_index (index),
        .wr_tag   (tag)
    );

    cache_way_array #(.TAG_W(TAG_W), .INDEX_W(INDEX_W)) u_way1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (flush),
        .rd_index (index),
        .rd_valid (valid1),
        .rd_tag   (tag1),
        .wr_en    (alloc && victim),
        .wr_index (index),
        .wr_tag   (tag)
    );

    // LRU bit holds the way to evict next.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lru_q <= '0;
        end else if (flush) begin
            lru_q <= '0;
        end else if (state) begin
            if (any_match) begin
                lru_q[index] <= match0;
            end else begin
                lru_q[index] <= !victim;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_q  <= '0;
            miss_q <= '0;
        end else if (state) begin
            if (ref_q != '1) begin
                ref_q <= ref_q + CNT_W'(1);
            end
            if (!any_match && (miss_q != '1)) begin
                miss_q <= miss_q + CNT_W'(1);
            end
        end
    end

    assign ref_count  = ref_q;
    assign miss_count = miss_q;

endmodule

// File: tb/tb_cache_lookup_responder.sv
// Directed vector bench for cache_lookup_responder: table of single-cycle
// lookups plus hand sequences for idle cycles and reset mid-search.
module tb_cache_lookup_responder;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr_in;
    logic        state;
    logic        flush;
    logic        hit;
    logic [31:0] ref_count;
    logic [31:0] miss_count;

    int unsigned n_checks;
    int unsigned n_fail;

    cache_lookup_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr_in    (addr_in),
        .state      (state),
        .flush      (flush),
        .hit        (hit),
        .ref_count  (ref_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        state;
        logic        flush;
        logic [31:0] addr;
        logic        exp_hit;
        int unsigned exp_ref;
        int unsigned exp_miss;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic f,
                                input logic [31:0] a, input logic h,
                                input int unsigned er, input int unsigned em);
        vec_t v;
        v.rst_n = r; v.state = s; v.flush = f; v.addr = a;
        v.exp_hit = h; v.exp_ref = er; v.exp_miss = em;
        return v;
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle, check hit mid-cycle and the counters after the edge.
    task automatic apply(input vec_t v, input string name);
        rst_n   = v.rst_n;
        state   = v.state;
        flush   = v.flush;
        addr_in = v.addr;
        #2;
        check({name, " hit"}, 32'(hit), 32'(v.exp_hit));
        @(posedge clk);
        #1;
        check({name, " ref_count"}, ref_count, v.exp_ref);
        check({name, " miss_count"}, miss_count, v.exp_miss);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        state    = 1'b0;
        flush    = 1'b0;
        addr_in  = '0;
        @(posedge clk);
        #1;

        // Index 0 lines: 0x1000 tag 2, 0x2000 tag 4, 0x3000 tag 6.
        vecs.push_back(mk(0, 0, 0, 32'h0000_0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0000_1000, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0000_1000, 0, 1, 1));
        vecs.push_back(mk(1, 1, 0, 32'h0000_1000, 1, 2, 1));
        vecs.push_back(mk(1, 1, 0, 32'h0000_101C, 1, 3, 1));
        vecs.push_back(mk(1, 1, 0, 32'h0000_1020, 0, 4, 2));
        vecs.push_back(mk(1, 1, 0, 32'h0000_2000, 0, 5, 3));
        vecs.push_back(mk(1, 1, 0, 32'h0000_3000, 0, 6, 4));
        vecs.push_back(mk(1, 1, 0, 32'h0000_2000, 1, 7, 4));
        vecs.push_back(mk(1, 1, 0, 32'h0000_1000, 0, 8, 5));
        vecs.push_back(mk(1, 1, 0, 32'h0000_3000, 0, 9, 6));
        vecs.push_back(mk(1, 1, 0, 32'h0000_1020, 1, 10, 6));

        foreach (vecs[i]) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Idle cycles with changing addresses, including cached ones.
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a;
            case (i % 3)
                0:       a = 32'h0000_1000;
                1:       a = 32'h0000_3000;
                default: a = $urandom;
            endcase
            apply(mk(1, 0, 0, a, 0, 10, 6), $sformatf("idle%0d", i));
        end

        // Contents survived idle: 0x1000 and 0x3000 still resident.
        apply(mk(1, 1, 0, 32'h0000_1000, 1, 11, 6), "post_idle_1000");
        apply(mk(1, 1, 0, 32'h0000_3000, 1, 12, 6), "post_idle_3000");

        // Flush during a hit: counted with pre-flush contents, no allocation.
        apply(mk(1, 1, 1, 32'h0000_1000, 1, 13, 6), "flush_search");
        apply(mk(1, 1, 0, 32'h0000_1000, 0, 14, 7), "after_flush_1000");
        apply(mk(1, 1, 0, 32'h0000_1000, 1, 15, 7), "refill_1000");
        apply(mk(1, 1, 0, 32'h0000_1020, 0, 16, 8), "after_flush_1020");

        // Reset during a search: lookup discarded, everything cleared.
        apply(mk(0, 1, 0, 32'h0000_1000, 0, 0, 0), "reset_mid_search");
        apply(mk(1, 1, 0, 32'h0000_1000, 0, 1, 1), "after_reset_1000");
        apply(mk(1, 1, 0, 32'h0000_1020, 0, 2, 2), "after_reset_1020");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
